// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: instruction fetch stage in front of the MIPS core.
// Owns the PC and issues word reads to an instruction memory with a fixed
// one-cycle read latency. Returned words are held in a DEPTH-entry FIFO of
// {pc, inst} and handed to the core. Redirects flush stale work, and halt
// freezes issue and presentation.
// Optional feature macro: FETCH_PERF_EN adds saturating perf_fetched and
// perf_squashed counters.
//
// Handshake: the core takes the head entry in any cycle where
// inst_valid & inst_ready are both 1. inst_valid never depends on inst_ready.
// imem_req depends combinationally on inst_ready, because a pop this cycle
// frees a FIFO slot for the word that returns next cycle.
module mips_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_b,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   input  logic        redirect_en,
   input  logic [31:0] redirect_pc,
   input  logic        halted
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_squashed
`endif
);

   localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int            CW      = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic          inflight_q, inflight_d;
   logic [31:0]   inflight_pc_q, inflight_pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [31:0]   pc_mem_q [DEPTH];
   logic [31:0]   pc_mem_d [DEPTH];
   logic [31:0]   inst_mem_q [DEPTH];
   logic [31:0]   inst_mem_d [DEPTH];

   logic          pop;
   logic          push;
   logic [CW-1:0] credit;

   // Redirect targets are always word aligned; the low bits are dropped.
   logic unused_redirect_lsbs;
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   // Head presentation from FIFO registers and the credit-based issue decision
   always_comb begin
      inst_valid = !rst_b && !halted && (count_q != '0);
      inst       = inst_mem_q[rd_ptr_q];
      inst_pc    = pc_mem_q[rd_ptr_q];
      pop        = inst_valid && inst_ready;
      // A redirect squashes whatever lands this cycle.
      push       = inflight_q && !redirect_en;
      // Slots committed after this cycle: entries kept plus the word in flight.
      credit     = count_q - CW'(pop) + CW'(inflight_q);
      imem_req   = !rst_b && !halted && !redirect_en && (credit < DEPTH_C);
      imem_addr  = fetch_pc_q;
   end

   // Next-state for PC, in-flight tracking and FIFO; a flush overrides push/pop
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_d    = imem_req;
      inflight_pc_d = inflight_pc_q;
      count_d       = count_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      pc_mem_d      = pc_mem_q;
      inst_mem_d    = inst_mem_q;
      if (imem_req) begin
         fetch_pc_d    = fetch_pc_q + 32'd4;
         inflight_pc_d = fetch_pc_q;
      end
      if (redirect_en) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end else begin
         if (push) begin
            pc_mem_d[wr_ptr_q]   = inflight_pc_q;
            inst_mem_d[wr_ptr_q] = imem_rdata;
            wr_ptr_d             = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // State registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (rst_b) begin
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         count_q       <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         pc_mem_q      <= '{default: '0};
         inst_mem_q    <= '{default: '0};
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         count_q       <= count_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         pc_mem_q      <= pc_mem_d;
         inst_mem_q    <= inst_mem_d;
      end
   end

   // The credit rule must never let a returning word land on a full FIFO
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         assert (!(push && (count_q == DEPTH_C)));
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched_q, perf_fetched_d;
   logic [31:0] perf_squashed_q, perf_squashed_d;
   logic [32:0] squash_sum;

   // Saturating counts of pushed entries and of squashed or flushed work
   always_comb begin
      perf_fetched_d = perf_fetched_q;
      if (push && (perf_fetched_q != 32'hFFFF_FFFF)) begin
         perf_fetched_d = perf_fetched_q + 32'd1;
      end
      squash_sum = {1'b0, perf_squashed_q};
      if (redirect_en) begin
         squash_sum = squash_sum + 33'(count_q) + 33'(inflight_q);
      end
      perf_squashed_d = squash_sum[32] ? 32'hFFFF_FFFF : squash_sum[31:0];
   end

   // Perf counter registers
   always_ff @(posedge clk) begin
      if (rst_b) begin
         perf_fetched_q  <= '0;
         perf_squashed_q <= '0;
      end else begin
         perf_fetched_q  <= perf_fetched_d;
         perf_squashed_q <= perf_squashed_d;
      end
   end

   assign perf_fetched  = perf_fetched_q;
   assign perf_squashed = perf_squashed_q;
`endif

endmodule
